ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 120 ++++++++++++
 tb/tb_ram_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_arbiter: round-robin arbiter giving two requesters access to one RAM    |
// | through a shared bidirectional data bus. Rev 1.0                            |
// +----------------------------------------------------------------------------+
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_ram_we,
  output logic              o_ram_en,
  output logic [ADDR_W-1:0] o_ram_addr,
  inout  wire  [DATA_W-1:0] io_ram_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last;
  logic                r_sel;
  logic                r_drive;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_any;
  logic                w_pick1;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  // r_last records who was served last; on contention the other side wins.
  assign w_any   = i_req0 | i_req1;
  assign w_pick1 = i_req1 & (~i_req0 | ~r_last);
  assign w_we    = w_pick1 ? i_we1    : i_we0;
  assign w_addr  = w_pick1 ? i_addr1  : i_addr0;
  assign w_wdata = w_pick1 ? i_wdata1 : i_wdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_sel     <= 1'b0;
      r_drive   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      o_gnt0    <= 1'b0;
      o_gnt1    <= 1'b0;
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_rdata   <= '0;
      o_ram_we  <= 1'b0;
      o_ram_en  <= 1'b0;
    end else begin
      o_gnt0    <= 1'b0;
      o_gnt1    <= 1'b0;
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
      o_ram_we  <= 1'b0;
      o_ram_en  <= 1'b0;
      r_drive   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel   <= w_pick1;
            r_last  <= w_pick1;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            o_gnt0  <= ~w_pick1;
            o_gnt1  <= w_pick1;
            if (w_we) begin
              r_state  <= S_WR;
              o_ram_we <= 1'b1;
              r_drive  <= 1'b1;
            end else begin
              r_state  <= S_RD;
              o_ram_en <= 1'b1;
            end
          end
        end
        S_WR: begin
          r_state <= S_IDLE;
        end
        S_RD: begin
          // The RAM drives the bus throughout the RD cycle; sample it at its end.
          r_state   <= S_IDLE;
          o_rdata   <= io_ram_data;
          o_rvalid0 <= ~r_sel;
          o_rvalid1 <= r_sel;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ram_addr  = r_addr;
  assign io_ram_data = r_drive ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ram_arbiter: bench for ram_arbiter with a small RAM on the shared bus.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rv0, rv1, ram_we, ram_en;
  logic [7:0] rdata;
  logic [3:0] ram_addr;
  wire  [7:0] ram_data;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM on the bus; when neither side should drive, it drives a zero probe so
  // any stray drive from the arbiter shows up as a wrong bus value.
  logic [7:0] ram_mem [16];
  logic [7:0] ram_drv;
  assign ram_drv  = ram_en ? ram_mem[ram_addr] : 8'h00;
  assign ram_data = (ram_en | ~ram_we) ? ram_drv : 8'hzz;

  always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_data;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rv0), .o_rvalid1(rv1),
    .o_rdata(rdata), .o_ram_we(ram_we), .o_ram_en(ram_en),
    .o_ram_addr(ram_addr), .io_ram_data(ram_data)
  );

  typedef struct packed {
    logic r0; logic w0; logic [3:0] a0; logic [7:0] d0;
    logic r1; logic w1; logic [3:0] a1; logic [7:0] d1;
    logic g0; logic g1; logic we; logic en; logic [3:0] addr; logic [7:0] bus;
    logic v0; logic v1; logic [7:0] rd;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input int r0, w0, a0, d0, r1, w1, a1, d1,
                              g0, g1, we, en, addr, bus, v0, v1, rd);
    vec_t v;
    v.r0 = r0[0]; v.w0 = w0[0]; v.a0 = a0[3:0]; v.d0 = d0[7:0];
    v.r1 = r1[0]; v.w1 = w1[0]; v.a1 = a1[3:0]; v.d1 = d1[7:0];
    v.g0 = g0[0]; v.g1 = g1[0]; v.we = we[0]; v.en = en[0];
    v.addr = addr[3:0]; v.bus = bus[7:0]; v.v0 = v0[0]; v.v1 = v1[0]; v.rd = rd[7:0];
    return v;
  endfunction

  function automatic logic [25:0] obs();
    return {gnt0, gnt1, ram_we, ram_en, ram_addr, ram_data, rv0, rv1, rdata};
  endfunction

  task automatic chk(input string nm, input logic [25:0] act, input logic [25:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: {g0,g1,we,en,addr,bus,rv0,rv1,rdata} got %h required %h",
               nm, $time, act, exp);
    end
  endtask

  task automatic drive(input int r0, w0, a0, d0, r1, w1, a1, d1);
    req0 = r0[0]; we0 = w0[0]; addr0 = a0[3:0]; wdata0 = d0[7:0];
    req1 = r1[0]; we1 = w1[0]; addr1 = a1[3:0]; wdata1 = d1[7:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole-run bus and grant exclusivity checks.
  initial begin
    forever begin
      @(negedge clk);
      n_checks++;
      if (gnt0 && gnt1) begin
        n_fail++;
        $display("FAIL gnt_excl @%0t: gnt0=%b gnt1=%b, required not both high", $time, gnt0, gnt1);
      end
      n_checks++;
      if (ram_en && ram_we) begin
        n_fail++;
        $display("FAIL en_we_excl @%0t: ram_en=1 ram_we=1, required not both high", $time);
      end
      n_checks++;
      if (ram_en && (ram_data !== ram_mem[ram_addr])) begin
        n_fail++;
        $display("FAIL bus_contention @%0t: bus=%h required RAM value %h", $time, ram_data, ram_mem[ram_addr]);
      end
    end
  end

  // Reference model state for the random phase.
  logic [7:0] m_mem [16];
  logic       m_last;
  logic       e_g0, e_g1, e_we, e_en, e_v0, e_v1, win, nv0, nv1;
  logic [3:0] e_addr;
  logic [7:0] e_bus, e_rd, exp_rd;
  logic [3:0] ia;
  logic [7:0] id;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //       r0 w0 a0 d0     r1 w1 a1 d1      g0 g1 we en ad bus    v0 v1 rd
    tbl[0]  = mk(1, 1, 3, 'hA5, 0, 0, 0, 0,    1, 0, 1, 0, 3, 'hA5, 0, 0, 'h00);
    tbl[1]  = mk(0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 3, 'h00, 0, 0, 'h00);
    tbl[2]  = mk(0, 0, 0, 0,    1, 0, 3, 0,    0, 1, 0, 1, 3, 'hA5, 0, 0, 'h00);
    tbl[3]  = mk(0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 3, 'h00, 0, 1, 'hA5);
    tbl[4]  = mk(0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 3, 'h00, 0, 0, 'hA5);
    tbl[5]  = mk(1, 1, 1, 'h11, 1, 1, 2, 'h22, 1, 0, 1, 0, 1, 'h11, 0, 0, 'hA5);
    tbl[6]  = mk(1, 1, 1, 'h11, 1, 1, 2, 'h22, 0, 0, 0, 0, 1, 'h00, 0, 0, 'hA5);
    tbl[7]  = mk(1, 1, 1, 'h11, 1, 1, 2, 'h22, 0, 1, 1, 0, 2, 'h22, 0, 0, 'hA5);
    tbl[8]  = mk(1, 1, 1, 'h11, 1, 1, 2, 'h22, 0, 0, 0, 0, 2, 'h00, 0, 0, 'hA5);
    tbl[9]  = mk(1, 1, 1, 'h11, 1, 1, 2, 'h22, 1, 0, 1, 0, 1, 'h11, 0, 0, 'hA5);
    tbl[10] = mk(0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 1, 'h00, 0, 0, 'hA5);
    tbl[11] = mk(0, 0, 0, 0,    1, 1, 5, 'h5A, 0, 1, 1, 0, 5, 'h5A, 0, 0, 'hA5);
    tbl[12] = mk(0, 0, 0, 0,    1, 1, 6, 'h6B, 0, 0, 0, 0, 5, 'h00, 0, 0, 'hA5);
    tbl[13] = mk(0, 0, 0, 0,    1, 1, 6, 'h6B, 0, 1, 1, 0, 6, 'h6B, 0, 0, 'hA5);
    tbl[14] = mk(0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 6, 'h00, 0, 0, 'hA5);
    tbl[15] = mk(1, 0, 5, 0,    0, 0, 0, 0,    1, 0, 0, 1, 5, 'h5A, 0, 0, 'hA5);
    tbl[16] = mk(0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 5, 'h00, 1, 0, 'h5A);
    tbl[17] = mk(1, 0, 6, 0,    1, 0, 5, 0,    0, 1, 0, 1, 5, 'h5A, 0, 0, 'h5A);
    tbl[18] = mk(1, 0, 6, 0,    0, 0, 0, 0,    0, 0, 0, 0, 5, 'h00, 0, 1, 'h5A);
    tbl[19] = mk(1, 0, 6, 0,    0, 0, 0, 0,    1, 0, 0, 1, 6, 'h6B, 0, 0, 'h5A);
    tbl[20] = mk(0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0, 6, 'h00, 1, 0, 'h6B);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", obs(), 26'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(int'(tbl[i].r0), int'(tbl[i].w0), int'(tbl[i].a0), int'(tbl[i].d0),
            int'(tbl[i].r1), int'(tbl[i].w1), int'(tbl[i].a1), int'(tbl[i].d1));
      tick();
      chk($sformatf("table_row%0d", i), obs(),
          {tbl[i].g0, tbl[i].g1, tbl[i].we, tbl[i].en, tbl[i].addr, tbl[i].bus,
           tbl[i].v0, tbl[i].v1, tbl[i].rd});
    end
    exp_rd = 8'h6B;

    // Fill all 16 locations through requester 0, read back through requester 1.
    for (int i = 0; i < 16; i++) begin
      ia = i[3:0]; id = i[7:0];
      drive(1, 1, i, i, 0, 0, 0, 0);
      tick();
      chk("fill_write", obs(), {1'b1, 1'b0, 1'b1, 1'b0, ia, id, 1'b0, 1'b0, exp_rd});
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      ia = i[3:0]; id = i[7:0];
      drive(0, 0, 0, 0, 1, 0, i, 0);
      tick();
      chk("fill_read_gnt", obs(), {1'b0, 1'b1, 1'b0, 1'b1, ia, id, 1'b0, 1'b0, exp_rd});
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("fill_read_data", obs(), {1'b0, 1'b0, 1'b0, 1'b0, ia, 8'h00, 1'b0, 1'b1, id});
      exp_rd = id;
    end

    // Reset in the middle of a read access.
    drive(0, 0, 0, 0, 1, 0, 3, 0);
    tick();
    chk("abort_rd_cycle", obs(), {1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 8'h03, 1'b0, 1'b0, exp_rd});
    #2 rst = 1'b1;
    #1 chk("abort_async_reset", obs(), 26'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("abort_no_rvalid", obs(), 26'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_reset_idle", obs(), 26'h0);
    drive(1, 1, 9, 'h99, 1, 1, 9, 'h77);
    tick();
    chk("first_contention_r0", obs(), {1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 8'h99, 1'b0, 1'b0, 8'h00});
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 9, 0);
    tick();
    chk("post_reset_rd_gnt", obs(), {1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 8'h99, 1'b0, 1'b0, 8'h00});
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("post_reset_rd_data", obs(), {1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 8'h00, 1'b0, 1'b1, 8'h99});

    // Random traffic against a transaction-level model.
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) m_mem[i] = i[7:0];
    m_mem[9] = 8'h99;
    m_last = 1'b1;
    e_g0 = 0; e_g1 = 0; e_we = 0; e_en = 0; e_v0 = 0; e_v1 = 0;
    e_addr = 4'd0; e_bus = 8'h00; e_rd = 8'h00;

    for (int c = 0; c < 2000; c++) begin
      chk("random_cycle", obs(), {e_g0, e_g1, e_we, e_en, e_addr, e_bus, e_v0, e_v1, e_rd});
      if (!req0 || e_g0)
        drive(int'($urandom_range(0, 99) < 55), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
              int'(req1), int'(we1), int'(addr1), int'(wdata1));
      if (!req1 || e_g1)
        drive(int'(req0), int'(we0), int'(addr0), int'(wdata0),
              int'($urandom_range(0, 99) < 55), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      if (e_g0 || e_g1) begin
        nv0 = e_en & e_g0;
        nv1 = e_en & e_g1;
        if (e_en) e_rd = m_mem[e_addr];
        e_g0 = 0; e_g1 = 0; e_we = 0; e_en = 0; e_bus = 8'h00;
        e_v0 = nv0; e_v1 = nv1;
      end else begin
        e_v0 = 0; e_v1 = 0;
        if (req0 || req1) begin
          win    = (req0 && req1) ? ~m_last : req1;
          m_last = win;
          e_g0   = ~win;
          e_g1   = win;
          e_we   = win ? we1 : we0;
          e_en   = ~e_we;
          e_addr = win ? addr1 : addr0;
          if (e_we) begin
            e_bus = win ? wdata1 : wdata0;
            m_mem[e_addr] = e_bus;
          end else begin
            e_bus = m_mem[e_addr];
          end
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
